// File: rtl/axi_ram_subordinate.sv
// AXI4-Lite subordinate backed by a word-organised RAM with programmable wait states.
// One transaction in flight at a time; a pending write beats a pending read in IDLE.
//
// Handshake rules: a transfer on any channel happens on the rising edge where both
// valid and ready are high. Every ready/valid driven here is decoded from the
// registered state only. A response valid stays high, with its payload frozen,
// until the matching ready is seen.
module axi_ram_subordinate #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [2:0]  dbg_state
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY);
    localparam logic [33:0] SPAN_BYTES = 34'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_WMEM = 3'd3,
        S_B    = 3'd4,
        S_AR   = 3'd5,
        S_RMEM = 3'd6,
        S_R    = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             mem_we;
    logic             cnt_done;

    // Decode the captured address; the byte offset is compared against the full
    // array span so that the low two address bits drop out naturally.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        in_range = (addr_q >= BASE_ADDR) && ({2'b00, offset} < SPAN_BYTES);
        idx      = offset[IDX_W+1:2];
        cnt_done = (cnt_q <= 4'd1);
        mem_we   = (state_q == S_WMEM) && cnt_done && in_range;
    end

    // State and datapath registers; the array itself is deliberately not reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            bresp_q <= 2'b00;
            rresp_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
        end
    end

    // Byte-lane write commit on the last wait-state cycle of WMEM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Next-state and next-data logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        bresp_d = bresp_q;
        rresp_d = rresp_q;
        case (state_q)
            S_IDLE: begin
                if (awvalid) begin
                    state_d = S_AW;
                end else if (arvalid) begin
                    state_d = S_AR;
                end
            end
            S_AW: begin
                if (awvalid) begin
                    addr_d  = awaddr;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (wvalid) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    cnt_d   = LAT_LOAD;
                    state_d = S_WMEM;
                end
            end
            S_WMEM: begin
                cnt_d = cnt_done ? 4'd0 : cnt_q - 4'd1;
                if (cnt_done) begin
                    bresp_d = in_range ? RESP_OKAY : RESP_SLV;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bready) begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                if (arvalid) begin
                    addr_d  = araddr;
                    cnt_d   = LAT_LOAD;
                    state_d = S_RMEM;
                end
            end
            S_RMEM: begin
                cnt_d = cnt_done ? 4'd0 : cnt_q - 4'd1;
                if (cnt_done) begin
                    rdata_d = in_range ? mem[idx] : 32'd0;
                    rresp_d = in_range ? RESP_OKAY : RESP_SLV;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded purely from registered state and data.
    always_comb begin
        awready   = (state_q == S_AW);
        wready    = (state_q == S_W);
        bvalid    = (state_q == S_B);
        arready   = (state_q == S_AR);
        rvalid    = (state_q == S_R);
        bresp     = bresp_q;
        rresp     = rresp_q;
        rdata     = rdata_q;
        dbg_state = state_q;
    end

endmodule
